// File: rtl/bcd_count_2digit_pkg.sv
// Shared definitions for the two-digit BCD counter: digit limit, run-state
// encoding and prescaler sizing / load saturation helpers.
package bcd_count_2digit_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    function automatic int presc_width(input int div);
        return $clog2(div);
    endfunction

    // Switch values above 9 are not valid BCD; clamp them to the largest digit.
    function automatic logic [3:0] bcd_sat(input logic [3:0] value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage

// File: rtl/bcd_count_2digit_sync.sv
// Input conditioner: SYNC_STAGES-deep synchronizer followed by a registered
// rising-edge detector producing a one-cycle pulse.
module btn_sync_edge
    import bcd_count_2digit_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = rise_q;

endmodule

// File: rtl/bcd_count_2digit.sv
// Two-digit BCD up/down counter with start/stop run state, clear, parallel
// load and a terminal-count pulse on every tick-caused wrap.
module bcd_count_2digit
    import bcd_count_2digit_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       load,
    input  logic       up_down,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       tc
);

    localparam int               PRE_W    = presc_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic ss_rise, clr_rise, ld_rise, count_up;
    logic ss_level_unused, clr_level_unused, ld_level_unused, ud_rise_unused;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .reset(reset), .din(start_stop), .level(ss_level_unused), .rise(ss_rise)
    );
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
        .clk(clk), .reset(reset), .din(clear), .level(clr_level_unused), .rise(clr_rise)
    );
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ld (
        .clk(clk), .reset(reset), .din(load), .level(ld_level_unused), .rise(ld_rise)
    );
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ud (
        .clk(clk), .reset(reset), .din(up_down), .level(count_up), .rise(ud_rise_unused)
    );

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       ones_q, ones_d, tens_q, tens_d;
    logic             tc_q, tc_d;
    logic             tick;

    assign tick = (state_q == ST_RUNNING) && (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        if (ss_rise) begin
            state_d = (state_q == ST_STOPPED) ? ST_RUNNING : ST_STOPPED;
        end
    end

    // Prescaler restarts whenever the count is disturbed so the first step
    // after a start, clear or load is always a full TICK_DIV period away.
    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
        if (state_q == ST_STOPPED || state_d == ST_STOPPED || clr_rise || ld_rise) begin
            pre_d = '0;
        end
    end

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        tc_d   = 1'b0;
        if (clr_rise) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (ld_rise) begin
            ones_d = bcd_sat(load_ones);
            tens_d = bcd_sat(load_tens);
        end else if (tick) begin
            if (count_up) begin
                if (ones_q == BCD_MAX) begin
                    ones_d = 4'd0;
                    if (tens_q == BCD_MAX) begin
                        tens_d = 4'd0;
                        tc_d   = 1'b1;
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (ones_q == 4'd0) begin
                    ones_d = BCD_MAX;
                    if (tens_q == 4'd0) begin
                        tens_d = BCD_MAX;
                        tc_d   = 1'b1;
                    end else begin
                        tens_d = tens_q - 4'd1;
                    end
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_STOPPED;
            pre_q   <= '0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            tc_q    <= tc_d;
        end
    end

    assign ones    = ones_q;
    assign tens    = tens_q;
    assign running = (state_q == ST_RUNNING);
    assign tc      = tc_q;

endmodule
